// File: rtl/ifq_pkg.sv
// ifq_pkg: shared entry type, NOP constant and pointer-width helper for the IF/ID fetch queue.
package ifq_pkg;
  localparam int IFQ_DATA_W = 32;
  localparam int IFQ_DEPTH = 4;
  localparam logic [31:0] IFQ_NOP = 32'h0000_0000;
  function automatic int ifq_ptr_w(input int depth);
    return $clog2(depth);
  endfunction
  localparam int IFQ_PTR_W = ifq_ptr_w(IFQ_DEPTH);
  typedef struct packed {
    logic [IFQ_DATA_W-1:0] instruction;
    logic [IFQ_DATA_W-1:0] pc_add4;
  } ifq_entry_t;
endpackage

// File: rtl/ifq_storage.sv
// ifq_storage: DEPTH-entry register array, one synchronous write port and one asynchronous read port.
module ifq_storage
  import ifq_pkg::*;
#(
  parameter int DEPTH = IFQ_DEPTH,
  parameter type entry_t = ifq_entry_t
)(
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  entry_t                   wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output entry_t                   rd_data
);
  entry_t mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end
  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/ifid_fetch_queue.sv
// ifid_fetch_queue: DEPTH-entry IF/ID FIFO with branch and exception flush.
// Defining IFQ_STATS_EN adds the saturating DropCount output.
module ifid_fetch_queue
  import ifq_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH = IFQ_DEPTH,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(IFQ_NOP)
)(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       Stall,
  input  logic                       Flush,
  input  logic                       ExceptionFlush,
  input  logic                       InValid,
  input  logic [DATA_W-1:0]          InInstruction,
  input  logic [DATA_W-1:0]          InPCAdd4,
  output logic                       InReady,
  output logic                       OutValid,
  output logic [DATA_W-1:0]          Instruction,
  output logic [DATA_W-1:0]          PCAdd4,
  output logic [$clog2(DEPTH+1)-1:0] Count,
  output logic                       ExcFlushed
`ifdef IFQ_STATS_EN
  ,
  output logic [15:0]                DropCount
`endif
);
  localparam int PTR_W = ifq_ptr_w(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  typedef struct packed {
    logic [DATA_W-1:0] instruction;
    logic [DATA_W-1:0] pc_add4;
  } entry_t;
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  entry_t wr_entry, rd_entry;
  logic any_flush, push, pop;
  assign any_flush = Flush | ExceptionFlush;
  // InReady depends on Count alone, so a full queue refuses a push even while popping
  assign InReady = Count != CNT_W'(DEPTH);
  assign OutValid = Count != '0;
  assign push = InValid & InReady & ~any_flush;
  assign pop = OutValid & ~Stall & ~any_flush;
  assign wr_entry = '{instruction: InInstruction, pc_add4: InPCAdd4};
  assign Instruction = OutValid ? rd_entry.instruction : NOP_WORD;
  assign PCAdd4 = OutValid ? rd_entry.pc_add4 : '0;
  ifq_storage #(.DEPTH(DEPTH), .entry_t(entry_t)) u_storage (
    .clk     (clk),
    .we      (push),
    .wr_addr (wr_ptr),
    .wr_data (wr_entry),
    .rd_addr (rd_ptr),
    .rd_data (rd_entry)
  );
  always_ff @(posedge clk) begin
    if (rst || any_flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      Count <= '0;
    end else begin
      rd_ptr <= rd_ptr + PTR_W'(pop);
      wr_ptr <= wr_ptr + PTR_W'(push);
      Count <= Count + CNT_W'(push) - CNT_W'(pop);
    end
    ExcFlushed <= ~rst & ExceptionFlush;
  end
`ifdef IFQ_STATS_EN
  logic [16:0] drop_sum;
  assign drop_sum = {1'b0, DropCount} + 17'(Count);
  always_ff @(posedge clk) begin
    if (rst) DropCount <= '0;
    else if (any_flush) DropCount <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end
`endif
endmodule

// File: tb/tb_ifid_fetch_queue.sv
// tb_ifid_fetch_queue: directed self-checking bench for ifid_fetch_queue (DEPTH=4).
module tb_ifid_fetch_queue;
  logic clk = 0;
  logic rst = 1, Stall = 0, Flush = 0, ExceptionFlush = 0, InValid = 0;
  logic [31:0] InInstruction = '0, InPCAdd4 = '0;
  logic InReady, OutValid, ExcFlushed;
  logic [31:0] Instruction, PCAdd4;
  logic [2:0] Count;
`ifdef IFQ_STATS_EN
  logic [15:0] DropCount;
`endif
  int total = 0, bad = 0;

  ifid_fetch_queue #(.DATA_W(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .Stall(Stall), .Flush(Flush), .ExceptionFlush(ExceptionFlush),
    .InValid(InValid), .InInstruction(InInstruction), .InPCAdd4(InPCAdd4),
    .InReady(InReady), .OutValid(OutValid), .Instruction(Instruction), .PCAdd4(PCAdd4),
    .Count(Count), .ExcFlushed(ExcFlushed)
`ifdef IFQ_STATS_EN
    , .DropCount(DropCount)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
    InValid = v;
    InInstruction = ins;
    InPCAdd4 = pc;
  endtask

  function automatic logic [31:0] wi(input int i);
    return 32'h1000_0000 + 32'(i);
  endfunction

  function automatic logic [31:0] wp(input int i);
    return 32'h0040_0000 + 32'(4 * i);
  endfunction

  initial begin
    tick();
    tick();
    chk("rst_count", 32'(Count), 0);
    chk("rst_outvalid", 32'(OutValid), 0);
    chk("rst_instr", Instruction, 0);
    chk("rst_pc", PCAdd4, 0);
    chk("rst_excflushed", 32'(ExcFlushed), 0);
    chk("rst_inready", 32'(InReady), 1);
`ifdef IFQ_STATS_EN
    chk("rst_drop", 32'(DropCount), 0);
`endif
    rst = 0;
    // single push, then popped next cycle
    drive(1, 32'h2408_0001, 32'h0040_0004);
    tick();
    chk("t1_outvalid", 32'(OutValid), 1);
    chk("t1_instr", Instruction, 32'h2408_0001);
    chk("t1_pc", PCAdd4, 32'h0040_0004);
    drive(0, '0, '0);
    tick();
    chk("t1_count_after", 32'(Count), 0);
    chk("t1_instr_after", Instruction, 0);
    // stalled fill to full, fifth word refused
    Stall = 1;
    for (int i = 1; i <= 5; i++) begin
      drive(1, wi(i), wp(i));
      tick();
    end
    chk("t2_count_full", 32'(Count), 4);
    chk("t2_inready_full", 32'(InReady), 0);
    chk("t2_head_w1", Instruction, wi(1));
    chk("t2_head_pc1", PCAdd4, wp(1));
    // full with simultaneous pop: push still refused
    Stall = 0;
    tick();
    chk("t2_full_pop_count", 32'(Count), 3);
    drive(0, '0, '0);
    for (int i = 2; i <= 4; i++) begin
      chk("t2_pop_instr", Instruction, wi(i));
      chk("t2_pop_pc", PCAdd4, wp(i));
      tick();
    end
    chk("t2_empty_outvalid", 32'(OutValid), 0);
    chk("t2_empty_inready", 32'(InReady), 1);
    // flush with three entries and an incoming word
    Stall = 1;
    for (int i = 10; i < 13; i++) begin
      drive(1, wi(i), wp(i));
      tick();
    end
    chk("t3_count3", 32'(Count), 3);
    Flush = 1;
    drive(1, wi(20), wp(20));
    tick();
    Flush = 0;
    drive(0, '0, '0);
    chk("t3_count", 32'(Count), 0);
    chk("t3_outvalid", 32'(OutValid), 0);
    chk("t3_instr", Instruction, 0);
    chk("t3_excflushed", 32'(ExcFlushed), 0);
`ifdef IFQ_STATS_EN
    chk("t3_drop", 32'(DropCount), 3);
`endif
    // flush + exception flush together
    for (int i = 30; i < 32; i++) begin
      drive(1, wi(i), wp(i));
      tick();
    end
    drive(0, '0, '0);
    chk("t4_count2", 32'(Count), 2);
    Flush = 1;
    ExceptionFlush = 1;
    tick();
    Flush = 0;
    ExceptionFlush = 0;
    chk("t4_count", 32'(Count), 0);
    chk("t4_outvalid", 32'(OutValid), 0);
    chk("t4_excflushed_hi", 32'(ExcFlushed), 1);
`ifdef IFQ_STATS_EN
    chk("t4_drop", 32'(DropCount), 5);
`endif
    tick();
    chk("t4_excflushed_lo", 32'(ExcFlushed), 0);
    // back-to-back exception flushes
    ExceptionFlush = 1;
    tick();
    chk("t4_b2b_1", 32'(ExcFlushed), 1);
    tick();
    chk("t4_b2b_2", 32'(ExcFlushed), 1);
    ExceptionFlush = 0;
    tick();
    chk("t4_b2b_end", 32'(ExcFlushed), 0);
    // streaming push/pop every cycle, pointer wrap
    Stall = 0;
    for (int k = 0; k < 12; k++) begin
      drive(1, wi(100 + k), wp(100 + k));
      tick();
      chk("t5_count", 32'(Count), 1);
      chk("t5_instr", Instruction, wi(100 + k));
      chk("t5_pc", PCAdd4, wp(100 + k));
    end
    drive(0, '0, '0);
    tick();
    chk("t5_drain", 32'(Count), 0);
    // reset mid-operation overrides exception flush
    Stall = 1;
    for (int i = 200; i < 202; i++) begin
      drive(1, wi(i), wp(i));
      tick();
    end
    drive(0, '0, '0);
    chk("t6_count2", 32'(Count), 2);
    rst = 1;
    ExceptionFlush = 1;
    tick();
    rst = 0;
    ExceptionFlush = 0;
    chk("t6_count", 32'(Count), 0);
    chk("t6_outvalid", 32'(OutValid), 0);
    chk("t6_inready", 32'(InReady), 1);
    chk("t6_excflushed", 32'(ExcFlushed), 0);
`ifdef IFQ_STATS_EN
    chk("t6_drop", 32'(DropCount), 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ifid_fetch_queue.md
Name: ifid_fetch_queue

Overview:
- Parametrised successor to the single-entry IF/ID register.
- A DEPTH-entry FIFO of {Instruction, PCAdd4} pairs between fetch and decode.
  - Lets IF keep fetching while ID stalls.
  - Keeps the two-flush model: Flush from branch resolve, ExceptionFlush from CP0.
  - Presents a NOP bubble to ID whenever no valid entry exists.

Parameters:
- DATA_W, 32, width of Instruction and PCAdd4.
- DEPTH, 4, number of entries; power of two, minimum 2.
- NOP_WORD, 32'h0000_0000, instruction presented when OutValid=0 (MIPS sll $0,$0,0).

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- Stall  input  1  ID cannot accept the head entry this cycle.
- Flush  input  1  branch/jump redirect; discard queue contents.
- ExceptionFlush  input  1  CP0 exception redirect; discard queue contents; highest priority.
- InValid  input  1  IF presents a fetched word this cycle.
- InInstruction  input  DATA_W  fetched instruction.
- InPCAdd4  input  DATA_W  PC+4 of fetched instruction.
- InReady  output  1  queue can accept a push (Count < DEPTH).
- OutValid  output  1  head entry valid.
- Instruction  output  DATA_W  head instruction, or NOP_WORD.
- PCAdd4  output  DATA_W  head PC+4, or 0.
- Count  output  $clog2(DEPTH+1)  occupied entries.
- ExcFlushed  output  1  one-cycle pulse, the cycle after an ExceptionFlush takes effect.

Behaviour:
- Reset (rst=1 at posedge):
  - read and write pointers 0; Count=0; OutValid=0.
  - Instruction=NOP_WORD; PCAdd4=0; ExcFlushed=0; InReady=1.
- Push: occurs when InValid && InReady and no flush is asserted.
- Pop: occurs when OutValid && !Stall and no flush is asserted.
- Latency: a pushed entry appears at the outputs on the cycle after the push edge. There is no same-cycle bypass.
- Outputs are driven from storage at the read pointer, gated by OutValid. When OutValid=0, outputs are NOP_WORD/0.
- InReady is a function of Count only (Count != DEPTH). It has no combinational path from Stall.
- Full with simultaneous pop: the push is refused (InReady=0). IF must hold its word.
- Empty: pop is impossible. A push lands and OutValid=1 on the next cycle.
- Pointer update:
  - Pointers are $clog2(DEPTH) bits and wrap naturally.
  - Count += push, -= pop.
  - Simultaneous push and pop leaves Count unchanged.
- Flush (and not ExceptionFlush):
  - Next cycle: pointers 0, Count=0, OutValid=0.
  - A same-cycle InValid word is discarded.
  - Stall is ignored.
- ExceptionFlush:
  - Same clearing as Flush.
  - Overrides Flush, push and pop.
  - ExcFlushed=1 for exactly the following cycle.
- Back-to-back ExceptionFlush cycles keep ExcFlushed high for each following cycle.
- Stall with a non-empty queue: head held stable; pushes continue until full.
- rst mid-operation overrides everything, including both flushes, and returns all state to reset values.
- Storage contents need no reset. They are never visible while OutValid=0.

Optional Feature:
- Macro: IFQ_STATS_EN.
- When defined:
  - Extra output DropCount, 16 bits.
  - Adds the number of valid entries discarded by each Flush/ExceptionFlush (Count at that edge). The same-cycle incoming word is not counted.
  - Saturates at 16'hFFFF.
  - Reset to 0 by rst.
- When undefined: the port and its logic are absent; behaviour is otherwise identical.

Decomposition:
- Package ifq_pkg:
  - typedef ifq_entry_t = struct {Instruction, PCAdd4}, each DATA_W.
  - Constant IFQ_NOP = 32'h0.
  - Helper localparam for pointer width.
- One natural sub-module: ifq_storage.
  - DEPTH x ifq_entry_t register array.
  - One synchronous write port and one asynchronous read port.
- Pointer, count and flush control remain in ifid_fetch_queue.

Test Plan:
1. Reset then push 0x24080001/0x00400004 with Stall=0 -> next cycle OutValid=1, Instruction=0x24080001, PCAdd4=0x00400004; the cycle after, Count=0 and Instruction=0.
2. Stall=1, push 5 words with DEPTH=4 -> Count=4, InReady=0, 5th word refused; head stays word 1. Release Stall -> words pop in order 1..4, one per cycle.
3. Fill 3 entries, assert Flush with InValid=1 -> next cycle Count=0, OutValid=0, Instruction=0; with IFQ_STATS_EN, DropCount=3.
4. Assert Flush and ExceptionFlush together -> queue cleared, ExcFlushed=1 for one cycle only, then 0.
5. Push/pop every cycle for 3*DEPTH cycles, Stall=0 -> Count constant at 1 and pointer wrap is exercised. The output sequence equals the input sequence delayed one cycle.
6. rst asserted with Count=2 and Stall=1 -> next cycle Count=0, OutValid=0, InReady=1, ExcFlushed=0 (DropCount=0 if enabled).
